// File: rtl/slc3_pkg.sv
// Shared SLC3 datapath types and sizes used by the register-file debug dump.
package slc3_pkg;

  localparam int unsigned SLC3_WORD_W      = 16;
  localparam int unsigned REGFILE_NUM_REGS = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CKSUM,
    DONE
  } dump_state_t;

endpackage

// File: rtl/reg_16.sv
// Existing SLC3 16-bit load-enabled register with synchronous reset.
module reg_16
  import slc3_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Load,
  input  logic [SLC3_WORD_W-1:0] D,
  output logic [SLC3_WORD_W-1:0] Data_Out
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Data_Out <= '0;
    end else if (Load) begin
      Data_Out <= D;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks the register file read port over R0..R(NUM_REGS-1) and streams tagged beats.
// Optional trailing checksum beat when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump
  import slc3_pkg::*;
#(
  parameter int unsigned NUM_REGS = REGFILE_NUM_REGS,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  output logic                   Busy,
  output logic                   Done,
  output logic [IDX_W-1:0]       RF_SR,
  input  logic [SLC3_WORD_W-1:0] RF_DATA,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [IDX_W-1:0]       Out_Idx,
  output logic [SLC3_WORD_W-1:0] Out_Data,
  output logic                   Out_Last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  dump_state_t            state;
  logic [IDX_W-1:0]       idx;
  logic [SLC3_WORD_W-1:0] held;
  logic                   data_blank;
  logic                   accept;

  assign accept = Out_Valid && Out_Ready;
  assign RF_SR  = idx;

  // Capture register has no reset of its own; blanking covers the post-reset window.
  reg_16 u_data_reg (
    .Clk      (Clk),
    .Reset    (1'b0),
    .Load     (state == READ),
    .D        (RF_DATA),
    .Data_Out (held)
  );

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [SLC3_WORD_W-1:0] acc;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc <= '0;
    end else if (state == IDLE && Start) begin
      acc <= '0;
    end else if (state == READ) begin
      acc <= acc + RF_DATA;
    end
  end

  assign Out_Data = (state == CKSUM) ? acc : (data_blank ? '0 : held);
`else
  assign Out_Data = data_blank ? '0 : held;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      idx        <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Out_Valid  <= 1'b0;
      Out_Idx    <= '0;
      Out_Last   <= 1'b0;
      data_blank <= 1'b1;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= READ;
            idx   <= '0;
            Busy  <= 1'b1;
          end
        end
        READ: begin
          state      <= SEND;
          Out_Valid  <= 1'b1;
          Out_Idx    <= idx;
          data_blank <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          Out_Last   <= 1'b0;
`else
          Out_Last   <= (idx == LAST_IDX);
`endif
        end
        SEND: begin
          if (accept) begin
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
            if (idx != LAST_IDX) begin
              idx   <= idx + IDX_W'(1);
              state <= READ;
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              state     <= CKSUM;
              Out_Valid <= 1'b1;
              Out_Idx   <= '0;
              Out_Last  <= 1'b1;
`else
              state <= DONE;
              Done  <= 1'b1;
`endif
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        CKSUM: begin
          if (accept) begin
            Out_Valid <= 1'b0;
            Out_Last  <= 1'b0;
            state     <= DONE;
            Done      <= 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: directed dumps with stalls, mid-dump writes, restart and reset.
module tb_regfile_dump;
  import slc3_pkg::*;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [2:0]  rf_sr;
  logic [15:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_idx;
  logic [15:0] out_data;
  logic        out_last;

  logic [15:0] rf [8];
  beat_t       sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;

  assign rf_data = rf[rf_sr];

  always #5 clk = ~clk;

  regfile_dump dut (
    .Clk       (clk),
    .Reset     (rst),
    .Start     (start),
    .Busy      (busy),
    .Done      (done),
    .RF_SR     (rf_sr),
    .RF_DATA   (rf_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_Idx   (out_idx),
    .Out_Data  (out_data),
    .Out_Last  (out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is compared against the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got idx %0d data 0x%0h, expected none", out_idx, out_data);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check("beat", 32'({out_idx, out_data, out_last}), 32'(e));
      end
    end
    if (!rst && done) done_cnt++;
  end

  task automatic preload();
    for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({busy, done, rf_sr, out_valid, out_idx, out_data, out_last}), 32'd0);
  endtask

  // One dump; idx arguments of -1 disable the corresponding event.
  task automatic run_dump(input int stall_idx, input int stall_n, input bit do_write,
                          input int start_idx, input int reset_idx, input int exp_done_cyc);
    int          cyc;
    int          done_cyc;
    int          stalled;
    int          done_base;
    bit          stalling;
    bit          in_read;
    bit          go_stall;
    bit          go_release;
    bit          go_start;
    bit          start_high;
    bit          go_reset;
    bit          wrote;
    logic [15:0] d;
    logic [15:0] sum;
    logic [15:0] stall_data;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      d = 16'(i * 16'h1111);
      if (do_write && i == 5) d = 16'hBEEF;
      sum = sum + d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sb_q.push_back(beat_t'{3'(i), d, 1'b0});
`else
      sb_q.push_back(beat_t'{3'(i), d, (i == 7)});
`endif
    end
`ifdef REGFILE_DUMP_CHECKSUM_EN
    sb_q.push_back(beat_t'{3'd0, sum, 1'b1});
`endif
    stall_data = 16'(stall_idx * 16'h1111);
    done_base = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("rf_sr_after_start", 32'(rf_sr), 32'd0);
    cyc = 1; done_cyc = -1; stalled = 0; stalling = 0; wrote = 0; start_high = 0;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      if (done) done_cyc = cyc;
      in_read    = busy && !out_valid && !done;
      go_stall   = in_read && (32'(rf_sr) == stall_idx) && !stalling && stall_n > 0;
      go_start   = in_read && (32'(rf_sr) == start_idx);
      go_reset   = in_read && (32'(rf_sr) == reset_idx);
      go_release = 1'b0;
      if (stalling && !out_ready) begin
        stalled++;
        check("stall_stable", 32'({out_valid, out_idx, out_data}),
              32'({1'b1, 3'(stall_idx), stall_data}));
        if (stalled == stall_n) go_release = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (start_high) begin start = 1'b0; start_high = 0; end
      if (go_start) begin start = 1'b1; start_high = 1; end
      if (go_stall) begin out_ready = 1'b0; stalling = 1; end
      if (stalling && do_write && !wrote) begin rf[5] = 16'hBEEF; wrote = 1; end
      if (go_release) begin out_ready = 1'b1; stalling = 0; stall_n = 0; end
      if (go_reset) begin
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_dump_outputs");
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("no_done_after_reset", 32'(done_cnt - done_base), 32'd0);
        rst = 1'b0;
        return;
      end
    end
    if (done_cyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no Done in %0d cycles, expected Done", cyc);
      return;
    end
    check("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
    @(negedge clk);
    check("busy_after_done", 32'({busy, done}), 32'd0);
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    check("done_count", 32'(done_cnt - done_base), 32'd1);
    repeat (3) @(negedge clk);
    check("idle_stays_idle", 32'({busy, out_valid}), 32'd0);
  endtask

  initial begin
    int extra;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    extra = 1;
`else
    extra = 0;
`endif
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    preload();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");

    run_dump(-1, 0, 1'b0, -1, -1, 17 + extra);   // basic walk
    run_dump(3, 5, 1'b0, -1, -1, 22 + extra);    // R3 beat stalled 5 cycles
    run_dump(2, 2, 1'b1, -1, -1, 19 + extra);    // R5 written while R2 stalled
    preload();
    run_dump(-1, 0, 1'b0, 4, -1, 17 + extra);    // Start pulse during R4 beat
    run_dump(-1, 0, 1'b0, -1, 6, 0);             // Reset during R6 beat
    @(posedge clk); #1;
    check_all_zero("idle_after_abort");
    run_dump(-1, 0, 1'b0, -1, -1, 17 + extra);   // restart from R0

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
